// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared mode encoding for the multi-mode flip-flop bank
package ff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_D  = 2'b00;
  localparam mode_t MODE_T  = 2'b01;
  localparam mode_t MODE_JK = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

endpackage : ff_pkg

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - single-bit next-state logic for D/T/JK/SR modes
import ff_pkg::*;

module ff_cell (
  input  mode_t mode_i,
  input  logic  a_i,
  input  logic  b_i,
  input  logic  q_i,
  output logic  q_next_o,
  output logic  viol_o
);

  // Next state for one channel; viol_o flags S=R=1 in SR mode and leaves q held
  always_comb begin
    q_next_o = q_i;
    viol_o   = 1'b0;
    unique case (mode_i)
      MODE_D:  q_next_o = a_i;
      MODE_T:  q_next_o = q_i ^ a_i;
      MODE_JK: begin
        unique case ({a_i, b_i})
          2'b00:   q_next_o = q_i;
          2'b01:   q_next_o = 1'b0;
          2'b10:   q_next_o = 1'b1;
          default: q_next_o = ~q_i;
        endcase
      end
      default: begin
        unique case ({a_i, b_i})
          2'b00:   q_next_o = q_i;
          2'b01:   q_next_o = 1'b0;
          2'b10:   q_next_o = 1'b1;
          default: begin
            q_next_o = q_i;
            viol_o   = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule : ff_cell

// File: rtl/multi_mode_ff_bank.sv
// rtl/multi_mode_ff_bank.sv - WIDTH-channel flip-flop bank with shared runtime mode
import ff_pkg::*;

module multi_mode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] sr_err
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] cell_next;
  logic [WIDTH-1:0] cell_viol;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .mode_i   (mode),
      .a_i      (a[i]),
      .b_i      (b[i]),
      .q_i      (q_q[i]),
      .q_next_o (cell_next[i]),
      .viol_o   (cell_viol[i])
    );
  end

  // Apply clr > en priority; violations only count on a real SR update, and a
  // fresh violation beats err_clr on the same bit
  always_comb begin
    q_d   = q_q;
    err_d = err_clr ? {WIDTH{1'b0}} : err_q;
    if (clr) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d   = cell_next;
      err_d = err_d | cell_viol;
    end
    chg_d = q_d ^ q_q;
  end

  // State registers with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      chg_q <= {WIDTH{1'b0}};
      err_q <= {WIDTH{1'b0}};
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      err_q <= err_d;
    end
  end

  assign q      = q_q;
  assign qn     = ~q_q;
  assign chg    = chg_q;
  assign sr_err = err_q;

endmodule : multi_mode_ff_bank

// File: tb/tb_multi_mode_ff_bank.sv
// tb/tb_multi_mode_ff_bank.sv - directed self-checking bench for multi_mode_ff_bank
import ff_pkg::*;

module tb_multi_mode_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  mode_t      mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       err_clr;
  logic [7:0] q, qn, chg, sr_err;
  logic       q1, qn1, chg1, err1;

  int checks;
  int errors;

  multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qn(qn), .chg(chg), .sr_err(sr_err)
  );

  multi_mode_ff_bank #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .a(a[0]), .b(b[0]), .err_clr(err_clr),
    .q(q1), .qn(qn1), .chg(chg1), .sr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one vector, clock it in, then sample 1 time unit after the edge
  task automatic step(input logic r, input logic c, input logic e, input logic ec,
                      input mode_t m, input logic [7:0] av, input logic [7:0] bv);
    rst = r; clr = c; en = e; err_clr = ec; mode = m; a = av; b = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; clr = 1'b0; en = 1'b0; err_clr = 1'b0; mode = MODE_D; a = '0; b = '0;
    @(negedge clk);

    // 1. reset with random inputs
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
         8'($urandom), 8'($urandom));
    check("rst_q", q, 8'h00);
    check("rst_qn", qn, 8'hFF);
    check("rst_chg", chg, 8'h00);
    check("rst_err", sr_err, 8'h00);
    check("w1_rst_q", {7'd0, q1}, 8'h01);
    check("w1_rst_qn", {7'd0, qn1}, 8'h00);

    // 2. toggle mode
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_T, 8'h0F, 8'h00);
    check("t1_q", q, 8'h0F);
    check("t1_chg", chg, 8'h0F);
    check("w1_t1_q", {7'd0, q1}, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_T, 8'h0F, 8'h00);
    check("t2_q", q, 8'h00);
    check("t2_chg", chg, 8'h0F);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_T, 8'h0F, 8'h00);
    check("t3_q", q, 8'h0F);
    check("t3_chg", chg, 8'h0F);
    check("t3_qn", qn, 8'hF0);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_T, 8'h00, 8'h00);
    check("t4_q", q, 8'h0F);
    check("t4_chg", chg, 8'h00);

    // clear back to zero before the D test
    step(1'b0, 1'b1, 1'b0, 1'b0, MODE_T, 8'hFF, 8'h00);
    check("clr0_q", q, 8'h00);
    check("clr0_chg", chg, 8'h0F);
    check("w1_clr_q", {7'd0, q1}, 8'h01);

    // 3. D mode and enable gating
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_D, 8'hA5, 8'h00);
    check("d_q", q, 8'hA5);
    check("d_chg", chg, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, MODE_D, 8'hFF, 8'h00);
    check("hold_q", q, 8'hA5);
    check("hold_chg", chg, 8'h00);

    // 4. JK mode
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_JK, 8'hF0, 8'h0F);
    check("jk1_q", q, 8'hF0);
    check("jk1_chg", chg, 8'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_JK, 8'hFF, 8'hFF);
    check("jk2_q", q, 8'h0F);
    check("jk2_chg", chg, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_JK, 8'h00, 8'h00);
    check("jk3_q", q, 8'h0F);
    check("jk3_chg", chg, 8'h00);

    // 5. SR mode and sticky violation flags
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_SR, 8'h30, 8'h03);
    check("sr1_q", q, 8'h3C);
    check("sr1_chg", chg, 8'h33);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_SR, 8'h81, 8'h81);
    check("sr2_q", q, 8'h3C);
    check("sr2_err", sr_err, 8'h81);
    step(1'b0, 1'b0, 1'b1, 1'b1, MODE_SR, 8'h01, 8'h01);
    check("sr3_err", sr_err, 8'h01);
    check("sr3_q", q, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b1, MODE_SR, 8'h00, 8'h00);
    check("sr4_err", sr_err, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_SR, 8'h02, 8'h02);
    check("sr5_err", sr_err, 8'h02);
    // violation not recorded when en=0
    step(1'b0, 1'b0, 1'b0, 1'b0, MODE_SR, 8'h40, 8'h40);
    check("sr6_err", sr_err, 8'h02);

    // 6. clr beats en, sr_err untouched
    step(1'b0, 1'b1, 1'b1, 1'b0, MODE_T, 8'hFF, 8'h00);
    check("clr1_q", q, 8'h00);
    check("clr1_chg", chg, 8'h3C);
    check("clr1_err", sr_err, 8'h02);
    step(1'b0, 1'b1, 1'b0, 1'b0, MODE_T, 8'hFF, 8'h00);
    check("clr2_q", q, 8'h00);
    check("clr2_chg", chg, 8'h00);

    // mid-sequence reset overrides everything
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_D, 8'h55, 8'h00);
    check("pre_rst_q", q, 8'h55);
    step(1'b1, 1'b0, 1'b1, 1'b0, MODE_SR, 8'hFF, 8'hFF);
    check("rst2_q", q, 8'h00);
    check("rst2_qn", qn, 8'hFF);
    check("rst2_chg", chg, 8'h00);
    check("rst2_err", sr_err, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_multi_mode_ff_bank

// File: doc/multi_mode_ff_bank.md
Name: multi_mode_ff_bank

Overview:
- Parametrised, edge-triggered bank of WIDTH independent flip-flop channels.
- All channels share a runtime-selectable mode: D, T, JK or SR.
- Generalises the single-bit level-sensitive toggle element into a synchronous, multi-channel, multi-mode storage block.
- Adds synchronous clear, a global enable, per-bit change pulses and sticky SR-violation flags. Used as a general-purpose state register for control logic and lab sequencers.

Parameters:
- WIDTH, 8, number of flip-flop channels (≥1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on rst and on clr.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global update enable; 0 = hold all channels.
- clr  input  1  synchronous clear of q to RESET_VAL (sr_err unaffected).
- mode  input  2  00=D, 01=T, 10=JK, 11=SR; sampled at each edge.
- a  input  WIDTH  per-bit D / T / J / S input.
- b  input  WIDTH  per-bit K / R input; ignored in D and T modes.
- err_clr  input  1  clears sr_err.
- q  output  WIDTH  registered state.
- qn  output  WIDTH  combinational ~q.
- chg  output  WIDTH  registered; bit i = 1 for one cycle if q[i] changed at the last edge.
- sr_err  output  WIDTH  sticky per-bit flag: S=R=1 seen while in SR mode.

Behaviour:
- Reset: one clock, synchronous and active-high. rst=1 at an edge gives q=RESET_VAL, chg=0, sr_err=0; qn=~RESET_VAL. Reset mid-operation overrides every other input in that cycle.
- Priority at each edge: rst > clr > en. clr=1 forces q=RESET_VAL whatever en/mode are.
- Latency: one cycle from inputs to q; qn follows q combinationally.
- en=0 and clr=0: q holds, chg=0, no SR error detection.
- Next-state per bit i, when en=1 and clr=0:
  - D: q=a.
  - T: q=q^a.
  - JK: J,K = 00 hold, 01 q=0, 10 q=1, 11 toggle.
  - SR: S,R = 00 hold, 01 q=0, 10 q=1, 11 hold and set sr_err[i].
- chg = q_next ^ q_current, registered alongside q. This applies to clr cycles too, so clr from 3C to 00 gives chg=3C.
- sr_err:
  - Set only in SR mode with en=1, clr=0 and a[i]&b[i].
  - Cleared by rst, or by err_clr at an edge.
  - If err_clr and a new violation occur in the same edge, the set wins for the violating bits; the other bits clear.
- mode changes take effect at the edge where the new value is sampled. No state is carried over beyond q.
- There is no wrap-around or counting state; each channel is independent. WIDTH=1 must work.

Decomposition:
- Shared package ff_pkg:
  - Mode constants MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11.
  - A typedef for the 2-bit mode.
- Sub-module ff_cell (one bit): inputs mode/a/b, current q; outputs next-q and violation.
  - Purely combinational next-state logic.
  - Instantiated WIDTH times by generate.
- The top level holds the q, chg and sr_err registers and the priority logic.

Test Plan (WIDTH=8, RESET_VAL=8'h00):
1. rst=1 for one edge with random inputs -> q=00, qn=FF, chg=00, sr_err=00. Assert rst mid-sequence later -> same result at that edge.
2. mode=T, en=1, a=0F for three edges -> q=0F,00,0F; chg=0F each cycle. Then a=00 -> q holds, chg=00.
3. mode=D, a=A5 -> q=A5, chg=A5 after one edge. Then en=0, a=FF -> q stays A5, chg=00.
4. mode=JK from q=A5: a=F0,b=0F -> q=F0. Then a=FF,b=FF -> q=0F. Then a=00,b=00 -> q=0F, chg=00.
5. mode=SR from q=0F:
   - a=30, b=03 -> q=3C.
   - a=81, b=81 -> q=3C, sr_err=81.
   - err_clr=1 with a=01, b=01 -> sr_err=01 (set wins on bit 0).
   - err_clr=1, a=b=00 -> sr_err=00.
6. q=3C, mode=T, a=FF, en=1, clr=1 -> q=00, chg=3C, sr_err unchanged. clr=1 with en=0 -> q=00.
